// File: rtl/seq_detect_stream.sv
// seq_detect_stream: serialises a parallel word MSB-first, counts pattern hits,
// and reports the per-word count over a valid/ready handshake.
module seq_detect_stream #(
  parameter int                 WIDTH   = 16,
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             serial_bit,
  output logic             bit_valid,
  output logic             det_pulse,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_odd
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FW = $clog2(PAT_LEN) + 1;
  localparam int HW = (PAT_LEN > 1) ? PAT_LEN - 1 : 1;

  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    REPORT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [HW-1:0]    hist;
  logic [HW-1:0]    hist_nxt;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_inc;
  logic [IW-1:0]    idx;
  logic [CNT_W-1:0] count;
  logic [PAT_LEN-1:0] win;
  logic             sbit;

  assign sbit = shreg[WIDTH-1];

  // The window's newest bit is the one on the wire right now.
  generate
    if (PAT_LEN > 2) begin : g_long
      assign win      = {hist, sbit};
      assign hist_nxt = {hist[HW-2:0], sbit};
    end else if (PAT_LEN == 2) begin : g_two
      assign win      = {hist, sbit};
      assign hist_nxt = sbit;
    end else begin : g_one
      assign win      = sbit;
      assign hist_nxt = sbit;
    end
  endgenerate

  assign fill_inc = (fill == FULL) ? fill : fill + 1'b1;

  assign det_pulse  = bit_valid && (fill >= FULL) && (win == PATTERN);
  assign serial_bit = bit_valid & sbit;
  assign out_count  = count;
  assign out_odd    = count[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      hist      <= '0;
      fill      <= '0;
      idx       <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      bit_valid <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            shreg     <= in_data;
            hist      <= '0;
            fill      <= '0;
            idx       <= '0;
            count     <= '0;
            in_ready  <= 1'b0;
            bit_valid <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          shreg <= shreg << 1;
          hist  <= hist_nxt;
          idx   <= idx + 1'b1;
          if (det_pulse) begin
            if (count != '1)
              count <= count + 1'b1;
            // Non-overlapping mode forgets the bits just consumed.
            fill <= OVERLAP ? fill_inc : '0;
          end else begin
            fill <= fill_inc;
          end
          if (idx == LAST) begin
            bit_valid <= 1'b0;
            out_valid <= 1'b1;
            state     <= REPORT;
          end
        end
        REPORT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_stream.sv
// tb_seq_detect_stream: three configurations driven in lockstep and checked
// against a per-word reference computed from whole-word bit arithmetic.
module tb_seq_detect_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = '0;

  logic        ir [3];
  logic        sb [3];
  logic        bv [3];
  logic        dp [3];
  logic        ov [3];
  logic        od [3];
  logic [4:0]  oc1;
  logic [4:0]  oc0;
  logic [1:0]  ocs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_detect_stream #(.OVERLAP(1'b1)) u_ovl (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .serial_bit(sb[0]), .bit_valid(bv[0]),
    .det_pulse(dp[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_count(oc1), .out_odd(od[0])
  );

  seq_detect_stream #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .serial_bit(sb[1]), .bit_valid(bv[1]),
    .det_pulse(dp[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_count(oc0), .out_odd(od[1])
  );

  seq_detect_stream #(
    .PAT_LEN(1), .PATTERN(1'b1), .OVERLAP(1'b1), .CNT_W(2)
  ) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .serial_bit(sb[2]), .bit_valid(bv[2]),
    .det_pulse(dp[2]), .out_valid(ov[2]), .out_ready(out_ready),
    .out_count(ocs), .out_odd(od[2])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oc_of(input int i);
    case (i)
      0: return int'(oc1);
      1: return int'(oc0);
      default: return int'(ocs);
    endcase
  endfunction

  // Reference: which bit positions complete a match, from the whole word.
  function automatic logic [15:0] hits(input logic [15:0] w,
                                       input logic [3:0] pat,
                                       input int plen, input bit ovl);
    logic [15:0] h;
    int last;
    bit m;
    h = '0;
    last = -100;
    for (int k = 0; k < 16; k++) begin
      m = (k >= plen - 1);
      if (m)
        for (int j = 0; j < plen; j++)
          if (w[15 - (k - plen + 1 + j)] != pat[plen - 1 - j]) m = 0;
      if (!ovl && (k - last < plen)) m = 0;
      if (m) begin
        h[k] = 1'b1;
        last = k;
      end
    end
    return h;
  endfunction

  function automatic int sat_pop(input logic [15:0] h, input int mx);
    int c;
    c = 0;
    for (int k = 0; k < 16; k++) c += int'(h[k]);
    return (c > mx) ? mx : c;
  endfunction

  int          cfg_len [3] = '{4, 4, 1};
  logic [3:0]  cfg_pat [3] = '{4'b1011, 4'b1011, 4'b0001};
  bit          cfg_ovl [3] = '{1'b1, 1'b0, 1'b1};
  int          cfg_max [3] = '{31, 31, 3};

  // Model phases: 0 waiting for a word, 1 scanning bit m_k, 2 reporting.
  int          m_phase = 0;
  int          m_k = 0;
  logic [15:0] m_word = '0;
  logic [15:0] m_hit [3];
  int          m_cnt [3];
  bit          armed = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_k = 0;
      armed = 1;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_word = in_data;
          for (int i = 0; i < 3; i++) begin
            m_hit[i] = hits(in_data, cfg_pat[i], cfg_len[i], cfg_ovl[i]);
            m_cnt[i] = sat_pop(m_hit[i], cfg_max[i]);
          end
          m_k = 0;
          m_phase = 1;
        end
        1: if (m_k == 15) m_phase = 2;
           else m_k++;
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        chk("in_ready", int'(ir[i]), int'(m_phase == 0));
        chk("bit_valid", int'(bv[i]), int'(m_phase == 1));
        chk("out_valid", int'(ov[i]), int'(m_phase == 2));
        chk("serial_bit", int'(sb[i]),
            (m_phase == 1) ? int'(m_word[15 - m_k]) : 0);
        chk("det_pulse", int'(dp[i]),
            (m_phase == 1) ? int'(m_hit[i][m_k]) : 0);
        if (m_phase == 2) begin
          chk("out_count", oc_of(i), m_cnt[i]);
          chk("out_odd", int'(od[i]), m_cnt[i] % 2);
        end
      end
    end
  end

  task automatic do_word(input logic [15:0] d, input int stall,
                         input int e1, input int e0, input int es);
    bit got;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = d;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = 16'($urandom);
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (ov[0]) got = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("out_valid_timeout", int'(got), 1);
    if (got) begin
      chk("lit_count_ovl", int'(oc1), e1);
      chk("lit_count_nov", int'(oc0), e0);
      chk("lit_count_sat", int'(ocs), es);
      chk("lit_odd_ovl", int'(od[0]), e1 % 2);
      for (int s = 0; s < stall; s++) begin
        in_valid = 1'b1;
        in_data = 16'($urandom);
        @(posedge clk); #1;
        chk("stall_valid", int'(ov[0]), 1);
        chk("stall_count", int'(oc1), e1);
        chk("stall_in_ready", int'(ir[0]), 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("valid_drop", int'(ov[0]), 0);
      chk("ready_back", int'(ir[0]), 1);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", int'(ir[0]), 1);
    chk("rst_out_valid", int'(ov[0]), 0);
    chk("rst_bit_valid", int'(bv[0]), 0);
    chk("rst_serial", int'(sb[0]), 0);
    chk("rst_det", int'(dp[0]), 0);
    chk("rst_count", int'(oc1), 0);
    chk("rst_odd", int'(od[0]), 0);

    do_word(16'b1011011011011011, 0, 5, 3, 3);
    do_word(16'hBBBB, 0, 4, 4, 3);
    do_word(16'hFFFF, 0, 0, 0, 3);
    do_word(16'h0005, 0, 0, 0, 2);
    do_word(16'hA000, 0, 0, 0, 2);
    do_word(16'h000B, 5, 1, 1, 3);
    do_word(16'h0001, 0, 0, 0, 1);

    // Reset while bit 7 of a word is on the wire.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = 16'hBBBB;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("mid_bit_valid", int'(bv[0]), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("after_rst_ready", int'(ir[0]), 1);
    chk("after_rst_valid", int'(ov[0]), 0);
    chk("after_rst_bitv", int'(bv[0]), 0);
    repeat (20) begin
      @(posedge clk); #1;
      chk("no_report", int'(ov[0]), 0);
    end
    do_word(16'hB000, 0, 1, 1, 3);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
